// File: rtl/id_imm_ext_pipe.sv
// ID-to-EX immediate stage: opcode-driven 16->32 bit immediate extension feeding
// a 2-entry valid/ready skid buffer. Define BRANCH_OFF_EN to add the out_br_off port.
module id_imm_ext_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic        out_is_imm,
  output logic        ext_sign
`ifdef BRANCH_OFF_EN
  ,
  output logic [31:0] out_br_off
`endif
);

  typedef enum logic [1:0] {
    EXT_NONE,
    EXT_SIGN,
    EXT_ZERO,
    EXT_UPPER
  } ext_mode_e;

  typedef struct packed {
    logic [31:0] imm;
    logic        is_imm;
    logic        sign;
`ifdef BRANCH_OFF_EN
    logic [31:0] br_off;
`endif
  } entry_t;

  logic [5:0] opcode;
  ext_mode_e  in_mode;
  entry_t     in_ent;

  // rs/rt fields are not consumed by the extender.
  logic unused_rs_rt;
  assign unused_rs_rt = ^in_instr[25:16];

  assign opcode = in_instr[31:26];

  always_comb begin
    unique case (opcode)
      6'h04, 6'h05,
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h23, 6'h2B: in_mode = EXT_SIGN;
      6'h0C, 6'h0D, 6'h0E: in_mode = EXT_ZERO;
      6'h0F:               in_mode = EXT_UPPER;
      default:             in_mode = EXT_NONE;
    endcase
  end

  always_comb begin
    // NOTE: every field gets a default before the case so no latch is inferred.
    in_ent = '0;
    case (in_mode)
      EXT_SIGN: begin
        in_ent.imm    = {{16{in_instr[15]}}, in_instr[15:0]};
        in_ent.is_imm = 1'b1;
        in_ent.sign   = 1'b1;
      end
      EXT_ZERO: begin
        in_ent.imm    = {16'h0000, in_instr[15:0]};
        in_ent.is_imm = 1'b1;
      end
      EXT_UPPER: begin
        in_ent.imm    = {in_instr[15:0], 16'h0000};
        in_ent.is_imm = 1'b1;
      end
      default: ;
    endcase
`ifdef BRANCH_OFF_EN
    if (opcode == 6'h04 || opcode == 6'h05) begin
      in_ent.br_off = {{14{in_instr[15]}}, in_instr[15:0], 2'b00};
    end
`endif
  end

  // Main (M) drives the outputs; skid (S) catches the one input accepted
  // while M is stalled, so in_ready never depends on out_ready.
  logic   m_valid_q, m_valid_d;
  logic   s_valid_q, s_valid_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;

  logic accept;
  logic pop;

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready;
  assign pop      = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_d       = m_q;
    s_d       = s_q;

    if (pop && s_valid_q) begin
      m_d       = s_q;
      m_valid_d = 1'b1;
      if (accept) begin
        s_d       = in_ent;
        s_valid_d = 1'b1;
      end else begin
        s_valid_d = 1'b0;
      end
    end else if (pop || !m_valid_q) begin
      if (accept) begin
        m_d       = in_ent;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_d       = in_ent;
      s_valid_d = 1'b1;
    end

    // Flush wins over any same-cycle accept or pop; payloads are don't-care.
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  // NOTE: payload registers are reset too, since the outputs must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_q       <= '0;
      s_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_q       <= m_d;
      s_q       <= s_d;
    end
  end

  assign out_valid  = m_valid_q;
  assign out_imm    = m_q.imm;
  assign out_is_imm = m_q.is_imm;
  assign ext_sign   = m_q.sign;
`ifdef BRANCH_OFF_EN
  assign out_br_off = m_q.br_off;
`endif

endmodule

// File: tb/tb_id_imm_ext_pipe.sv
// Self-checking bench for id_imm_ext_pipe: directed cases plus random traffic
// compared against a queue-based reference of the extender and 2-deep FIFO.
module tb_id_imm_ext_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_is_imm;
  logic        ext_sign;
`ifdef BRANCH_OFF_EN
  logic [31:0] out_br_off;
`endif

  id_imm_ext_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_is_imm (out_is_imm),
    .ext_sign   (ext_sign)
`ifdef BRANCH_OFF_EN
    ,
    .out_br_off (out_br_off)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] imm;
    logic        is_imm;
    logic        sign;
    logic [31:0] br;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t        e;
    logic [5:0]  op;
    int          s;
    int unsigned u;
    op = i[31:26];
    s  = $signed(i[15:0]);
    u  = i[15:0];
    e  = '{imm: 32'd0, is_imm: 1'b0, sign: 1'b0, br: 32'd0};
    if (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B}) begin
      e.imm    = 32'(s);
      e.is_imm = 1'b1;
      e.sign   = 1'b1;
      if (op inside {6'h04, 6'h05}) e.br = 32'(s * 4);
    end else if (op inside {6'h0C, 6'h0D, 6'h0E}) begin
      e.imm    = u;
      e.is_imm = 1'b1;
    end else if (op == 6'h0F) begin
      e.imm    = u * 32'd65536;
      e.is_imm = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk({tag, ".out_imm"}, out_imm, q[0].imm);
      chk({tag, ".out_is_imm"}, 32'(out_is_imm), 32'(q[0].is_imm));
      chk({tag, ".ext_sign"}, 32'(ext_sign), 32'(q[0].sign));
`ifdef BRANCH_OFF_EN
      chk({tag, ".out_br_off"}, out_br_off, q[0].br);
`endif
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".out_imm"}, out_imm, 32'd0);
    chk({tag, ".out_is_imm"}, 32'(out_is_imm), 32'd0);
    chk({tag, ".ext_sign"}, 32'(ext_sign), 32'd0);
`ifdef BRANCH_OFF_EN
    chk({tag, ".out_br_off"}, out_br_off, 32'd0);
`endif
  endtask

  task automatic expect_head(input string tag, input logic [31:0] imm,
                             input logic is_imm, input logic sign);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".imm"}, out_imm, imm);
    chk({tag, ".is_imm"}, 32'(out_is_imm), 32'(is_imm));
    chk({tag, ".sign"}, 32'(ext_sign), 32'(sign));
  endtask

  // Drive one cycle at the falling edge, advance the model at the rising
  // edge, then compare at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] instr,
                       input logic ordy, input logic fl, input string tag);
    int  pre;
    bit  acc;
    bit  pp;
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    pre = q.size();
    acc = v && (pre < 2);
    pp  = ordy && (pre > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(instr));
    end
    @(negedge clk);
    check_state(tag);
  endtask

  logic [5:0] ops [14] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                           6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00, 6'h3F};

  initial begin
    logic [31:0] r;
    logic [5:0]  op;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    cycle(1'b1, 32'h2008FFFC, 1'b1, 1'b0, "addi");
    expect_head("addi_k", 32'hFFFFFFFC, 1'b1, 1'b1);
    cycle(1'b1, 32'h3508FFFC, 1'b1, 1'b0, "ori");
    expect_head("ori_k", 32'h0000FFFC, 1'b1, 1'b0);
    cycle(1'b1, 32'h3C081234, 1'b1, 1'b0, "lui");
    expect_head("lui_k", 32'h12340000, 1'b1, 1'b0);
    cycle(1'b1, 32'h01095020, 1'b1, 1'b0, "rtype");
    expect_head("rtype_k", 32'h00000000, 1'b0, 1'b0);
    cycle(1'b1, 32'h1109FFFF, 1'b1, 1'b0, "beq");
    expect_head("beq_k", 32'hFFFFFFFF, 1'b1, 1'b1);
`ifdef BRANCH_OFF_EN
    chk("beq_k.br_off", out_br_off, 32'hFFFFFFFC);
`endif
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "drain0");

    cycle(1'b1, 32'h20080001, 1'b0, 1'b0, "bp_a");
    cycle(1'b1, 32'h34080002, 1'b0, 1'b0, "bp_b");
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h3C080003, 1'b0, 1'b0, "bp_c_blocked");
    expect_head("bp_head_a", 32'h00000001, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "bp_pop1");
    expect_head("bp_head_b", 32'h00000002, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "bp_pop2");
    chk("bp_empty", 32'(out_valid), 32'd0);

    cycle(1'b1, 32'h20080001, 1'b0, 1'b0, "fl_a");
    cycle(1'b1, 32'h34080002, 1'b0, 1'b0, "fl_b");
    cycle(1'b1, 32'h3C080003, 1'b1, 1'b1, "flush");
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, "flush_after");
    chk("flush_dropped", 32'(out_valid), 32'd0);

    for (int i = 0; i < 400; i++) begin
      r  = $urandom();
      op = ops[$urandom_range(0, 13)];
      cycle(1'($urandom_range(0, 3) != 0), {op, r[25:0]},
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0), "rand");
    end

    cycle(1'b1, 32'h20080001, 1'b0, 1'b0, "ar_a");
    cycle(1'b1, 32'h34080002, 1'b0, 1'b0, "ar_b");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'h3C080003, 1'b1, 1'b0, "post_reset");
    expect_head("post_reset_k", 32'h00030000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
